// File: rtl/fetch_unit.sv
// fetch_unit: KLP32 instruction fetch, PC plus single-outstanding imem request/response handshake.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect sets misalign_o and halts fetch until reset.
module fetch_unit #(
  parameter int n = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         pc_sel_i,
  input  logic [n-1:0] alu_target_i,
  input  logic         instr_ready_i,
  output logic [n-1:0] instr_o,
  output logic         instr_valid_o,
  output logic [n-1:0] pc_o,
  output logic [n-1:0] pc_plus4_o,
  output logic         imem_req_o,
  output logic [n-1:0] imem_addr_o,
  input  logic         imem_ready_i,
  input  logic         imem_rvalid_i,
  input  logic [n-1:0] imem_rdata_i,
  output logic         misalign_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
  localparam logic [n-1:0] NOP = n'(32'h0000_0013);
  state_t       state_q;
  logic [n-1:0] fetch_pc_q, pc_q, instr_q, target_d, next_pc_d;
  logic         valid_q, req_q, misalign_q, trap_d;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_d = alu_target_i;
  assign trap_d   = pc_sel_i && (alu_target_i[1:0] != 2'b00);
`else
  logic unused_lsb;
  assign unused_lsb = ^alu_target_i[1:0];
  assign target_d   = {alu_target_i[n-1:2], 2'b00};
  assign trap_d     = 1'b0;
`endif
  assign next_pc_d     = pc_sel_i ? target_d : pc_q + n'(4);
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + n'(4);
  assign imem_req_o    = req_q;
  assign imem_addr_o   = fetch_pc_q;
  assign misalign_o    = misalign_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: if (imem_ready_i) begin
          state_q <= WAIT;
          req_q   <= 1'b0;
        end
        WAIT: if (imem_rvalid_i) begin
          state_q <= HOLD;
          instr_q <= imem_rdata_i;
          pc_q    <= fetch_pc_q;
          valid_q <= 1'b1;
        end
        HOLD: if (instr_ready_i) begin
          valid_q <= 1'b0;
          if (trap_d) begin
            state_q    <= HALT;
            misalign_q <= 1'b1;
          end else begin
            state_q    <= REQ;
            req_q      <= 1'b1;
            fetch_pc_q <= next_pc_d;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit with a 1-cycle imem model driven from tasks.
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        clk = 0, rst_n = 0, pc_sel = 0, instr_ready = 0, imem_ready = 0, imem_rvalid = 0;
  logic [31:0] alu_target = 0, imem_rdata = 0, instr, pc, pc_plus4, imem_addr, hold_instr;
  logic        instr_valid, imem_req, misalign;
  logic        pend = 0;
  logic [31:0] pend_addr = 0;
  int checks = 0, fails = 0;

  fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .pc_sel_i(pc_sel), .alu_target_i(alu_target),
    .instr_ready_i(instr_ready), .instr_o(instr), .instr_valid_o(instr_valid), .pc_o(pc),
    .pc_plus4_o(pc_plus4), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ready_i(imem_ready), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // memory answers one cycle after each accepted request with addr ^ K
  task automatic step();
    imem_rvalid = pend;
    imem_rdata  = pend_addr ^ K;
    pend        = imem_req && imem_ready;
    pend_addr   = imem_addr;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; imem_ready = 1;
    cyc(); cyc();
    checks++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (instr !== 32'h13) begin fails++; $display("FAIL reset_instr got %h want 00000013", instr); end
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (misalign !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b want 0", misalign); end
    rst_n = 1; imem_rvalid = 0; pend = 0;
    cyc();
    checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL first_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_sequential();
    instr_ready = 1; pc_sel = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin fails++; $display("FAIL seq_req%0d got req=%b addr=%h want 1/%h", k, imem_req, imem_addr, 4*k); end
      step();
      checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin fails++; $display("FAIL seq_wait%0d got req=%b valid=%b want 0/0", k, imem_req, instr_valid); end
      step();
      checks++; if (instr_valid !== 1'b1 || pc !== 32'(4*k) || instr !== (32'(4*k) ^ K)) begin fails++; $display("FAIL seq_hold%0d got v=%b pc=%h instr=%h want 1/%h/%h", k, instr_valid, pc, instr, 4*k, 32'(4*k) ^ K); end
      if (k < 2) step();
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 0;
    hold_instr = 32'h8 ^ K;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (instr !== hold_instr || pc !== 32'h8 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin fails++; $display("FAIL bp%0d got instr=%h pc=%h v=%b req=%b want %h/8/1/0", i, instr, pc, instr_valid, imem_req, hold_instr); end
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1; pc_sel = 1; alu_target = 32'h100;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin fails++; $display("FAIL redir got req=%b addr=%h v=%b want 1/100/0", imem_req, imem_addr, instr_valid); end
    pc_sel = 0; alu_target = 32'h5555_5554; imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin fails++; $display("FAIL stall%0d got req=%b addr=%h want 1/100", i, imem_req, imem_addr); end
    end
    imem_ready = 1;
    step(); step();
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h100 || instr !== (32'h100 ^ K)) begin fails++; $display("FAIL redir_fetch got v=%b pc=%h instr=%h want 1/100/%h", instr_valid, pc, instr, 32'h100 ^ K); end
    step();
    checks++; if (imem_addr !== 32'h104) begin fails++; $display("FAIL redir_next got %h want 104", imem_addr); end
    step(); step();
    checks++; if (pc !== 32'h104 || instr !== (32'h104 ^ K)) begin fails++; $display("FAIL redir_follow got pc=%h instr=%h want 104/%h", pc, instr, 32'h104 ^ K); end
  endtask

  task automatic test_wrap();
    pc_sel = 1; alu_target = 32'hFFFF_FFFC;
    step();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
    pc_sel = 0;
    step(); step();
    checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_pc got pc=%h pc4=%h want fffffffc/0", pc, pc_plus4); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_next got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    step(); step();
  endtask

  task automatic test_misalign();
    pc_sel = 1; alu_target = 32'h102;
    step();
    pc_sel = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (misalign !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL mis_flag got m=%b v=%b want 1/0", misalign, instr_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_req !== 1'b0 || misalign !== 1'b1) begin fails++; $display("FAIL mis_halt%0d got req=%b m=%b want 0/1", i, imem_req, misalign); end
    end
`else
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || misalign !== 1'b0) begin fails++; $display("FAIL mis_align got req=%b addr=%h m=%b want 1/100/0", imem_req, imem_addr, misalign); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    rst_n = 0; pend = 0; cyc();
    rst_n = 1; cyc();
    step();
    checks++; if (imem_req !== 1'b0 || pend !== 1'b1) begin fails++; $display("FAIL mw_wait got req=%b pend=%b want 0/1", imem_req, pend); end
    rst_n = 0;
    step();
    checks++; if (instr_valid !== 1'b0 || pc !== 32'h0 || instr !== 32'h13 || imem_req !== 1'b0 || misalign !== 1'b0) begin fails++; $display("FAIL mw_drop got v=%b pc=%h instr=%h req=%b m=%b want 0/0/13/0/0", instr_valid, pc, instr, imem_req, misalign); end
    rst_n = 1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL mw_refetch got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    step(); step();
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== K) begin fails++; $display("FAIL mw_data got v=%b pc=%h instr=%h want 1/0/%h", instr_valid, pc, instr, K); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_misalign();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the KLP32 RV32I core. Holds the program counter, issues word reads to instruction memory through a request/response handshake, and presents one registered instruction at a time to the decode/control stage. Sits directly upstream of `control`: drives its `instr` input and consumes its `PCSel` output, together with the ALU result, to select the next PC.

## Interface

- `n`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `PCSel`  in  1  from `control`; 1 = next PC is `alu_target`, 0 = `pc + 4`
- `alu_target`  in  n  branch/jump target from ALU
- `instr_ready`  in  1  decode stage accepts `instr` this cycle
- `instr`  out  n  registered instruction to `control`
- `instr_valid`  out  1  `instr`/`pc` hold a fetched instruction
- `pc`  out  n  address of `instr`
- `pc_plus4`  out  n  `pc + 4` (combinational from `pc`), for JAL/JALR writeback
- `imem_req`  out  1  read request
- `imem_addr`  out  n  read address, word-aligned
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  n  read data
- `misalign`  out  1  sticky misaligned-target flag (see Configuration)

## Operation

- Registers: `fetch_pc` (next address to fetch), `pc`, `instr`, `instr_valid`, `misalign`, state.
- FSM states: IDLE, REQ, WAIT, HOLD, HALT.
  - IDLE: entered on reset; unconditionally -> REQ next cycle.
  - REQ: `imem_req=1`, `imem_addr=fetch_pc`. `imem_ready=1` -> WAIT; else stay, address held stable.
  - WAIT: `imem_req=0`. On `imem_rvalid`: `instr<=imem_rdata`, `pc<=fetch_pc`, `instr_valid<=1` -> HOLD. Otherwise stay (unbounded latency).
  - HOLD: `instr`, `pc` stable. On `instr_valid && instr_ready` (handshake): `instr_valid<=0`; `fetch_pc <= PCSel ? alu_target : pc + 4` -> REQ (or HALT, see Configuration). Otherwise stay.
  - HALT: only with `FETCH_MISALIGN_TRAP_EN`; no requests, `instr_valid=0`; exits only by reset.
- Exactly one outstanding memory request; `imem_rvalid` outside WAIT is ignored.
- `PCSel` and `alu_target` sampled only at the HOLD handshake; ignored otherwise.
- PC arithmetic modulo 2^n: `pc = 32'hFFFF_FFFC` -> next `fetch_pc = 0`.

## Timing

- Reset (`rst_n=0` at a rising edge): `fetch_pc=RESET_PC`, `pc=RESET_PC`, `instr=32'h0000_0013` (NOP), `instr_valid=0`, `imem_req=0`, `misalign=0`, state IDLE. Reset overrides every other event, including a response arriving in the same cycle; in-flight responses are dropped (imem shares `rst_n`).
- First `imem_req` in the 2nd cycle after `rst_n` goes high.
- Request accepted at edge E (REQ, `imem_ready=1`); earliest `imem_rvalid` in the cycle after E; `instr_valid` rises at the edge sampling `imem_rvalid`.
- With 1-cycle memory, `imem_ready=1`, `instr_ready=1`: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Handshake and new request never in the same cycle; `imem_req` asserted the cycle after the handshake.

## Configuration

- `FETCH_MISALIGN_TRAP_EN` defined: a handshake with `alu_target[1:0] != 0` (PCSel=1) sets `misalign<=1` and enters HALT; no further `imem_req` until reset.
- Undefined: `misalign` tied 0; `fetch_pc` takes `{alu_target[n-1:2], 2'b00}`; HALT is unreachable.

## Test plan

- Reset: hold `rst_n=0` 2 cycles with `imem_rvalid=1` -> `pc=0`, `instr=32'h00000013`, `instr_valid=0`, `imem_req=0`; after release, `imem_req=1`, `imem_addr=0` in 2nd cycle.
- Sequential: 1-cycle memory returning `addr ^ 32'hA5A5_0000`, `instr_ready=1`, `PCSel=0` -> `imem_addr` 0,4,8; `instr_valid` every 3 cycles with `pc` 0,4,8 and matching data.
- Back-pressure and memory stall: `instr_ready=0` 5 cycles -> `instr`,`pc` stable, `imem_req=0`; `imem_ready=0` 3 cycles in REQ -> `imem_req=1`, `imem_addr` unchanged.
- Redirect: handshake at `pc=8` with `PCSel=1`, `alu_target=32'h100` -> next `imem_addr=32'h100`, following fetch `pc=32'h104`.
- Misaligned target `32'h102`: with macro -> `misalign=1`, no further `imem_req`; without -> `imem_addr=32'h100`, `misalign=0`.
- Reset mid-WAIT: assert `rst_n=0` one cycle while request outstanding, response arrives same cycle -> response dropped, `instr_valid=0`, refetch from `RESET_PC`.
